secuenciador_alu: RTL and testbench

SECUENCIADOR_ALU -- requirements
Module: secuenciador_alu

---
 rtl/secuenciador_alu_pkg.sv | 39 +++
 rtl/secuenciador_alu_if.sv | 44 ++++
 rtl/alu_8b.sv | 41 ++++
 rtl/banco_registros.sv | 47 ++++
 rtl/secuenciador_alu.sv | 136 +++++++++++++
 tb/tb_secuenciador_alu.sv | 221 ++++++++++++++++++++++
 6 files changed

// File: rtl/secuenciador_alu_pkg.sv
// Purpose : shared opcode constants, FSM state encoding and opcode helpers.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package secuenciador_alu_pkg;

  // Opcodes carried in instruccion[7:4]. Only 1xxx opcodes write back.
  localparam logic [3:0] OP_NOP      = 4'b0000;
  localparam logic [3:0] OP_SUMA     = 4'b1000;
  localparam logic [3:0] OP_RESTA    = 4'b1001;
  localparam logic [3:0] OP_DESP_IZQ = 4'b1010;
  localparam logic [3:0] OP_DESP_DER = 4'b1011;
  localparam logic [3:0] OP_NOT      = 4'b1100;
  localparam logic [3:0] OP_AND      = 4'b1101;
  localparam logic [3:0] OP_OR       = 4'b1110;
  localparam logic [3:0] OP_XOR      = 4'b1111;

  // Flag bit positions as produced by the external ALU.
  localparam int FLAG_CERO     = 0;
  localparam int FLAG_NEGATIVO = 1;
  localparam int FLAG_ACARREO  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEE     = 2'd1,
    EJECUTA = 2'd2,
    FIN     = 2'd3
  } estado_t;

  // Every opcode with the top bit set is a real ALU operation.
  function automatic logic op_escribe(input logic [3:0] op);
    return op[3];
  endfunction

  // 0001..0111 are reserved: they complete like a NOP but flag an error.
  function automatic logic op_invalido(input logic [3:0] op);
    return (op != OP_NOP) && !op[3];
  endfunction

endpackage

// File: rtl/secuenciador_alu_if.sv
// Purpose : host-side and ALU-side signals of the sequencer in one bundle.
// Latency : n/a (wiring only).
// Backpr. : none; the host must watch ocupado, requests while busy are dropped.
// Modports: master = host (issues instructions / loads), slave = sequencer,
//           alu = external combinational ALU.
interface secuenciador_alu_if;
  // host request / load port
  logic       inicio;
  logic [7:0] instruccion;
  logic       carga_en;
  logic [1:0] carga_dir;
  logic [7:0] carga_dato;
  // host status
  logic       ocupado;
  logic       listo;
  logic       error;
  logic [7:0] r0_actual;
  logic [2:0] banderas;
  logic [7:0] cuenta_ops;
  // ALU operands and results
  logic [7:0] R0_alu;
  logic [7:0] RX_alu;
  logic [3:0] Operacion_alu;
  logic [7:0] Resultado_alu;
  logic [2:0] Banderas_alu;

  modport master (
    output inicio, instruccion, carga_en, carga_dir, carga_dato,
    input  ocupado, listo, error, r0_actual, banderas, cuenta_ops
  );

  modport slave (
    input  inicio, instruccion, carga_en, carga_dir, carga_dato,
    output ocupado, listo, error, r0_actual, banderas, cuenta_ops,
    output R0_alu, RX_alu, Operacion_alu,
    input  Resultado_alu, Banderas_alu
  );

  modport alu (
    input  R0_alu, RX_alu, Operacion_alu,
    output Resultado_alu, Banderas_alu
  );

endinterface

// File: rtl/alu_8b.sv
// Purpose : external combinational 8-bit ALU driven by the sequencer.
// Latency : combinational, zero cycles.
// Backpr. : none.
// Ports   : bus.alu modport: R0_alu/RX_alu/Operacion_alu in,
//           Resultado_alu and Banderas_alu {acarreo, negativo, cero} out.
module alu_8b
  import secuenciador_alu_pkg::*;
(
  secuenciador_alu_if.alu bus
);

  logic [7:0] res;
  logic       acarreo;
  logic [7:0] a;
  logic [7:0] b;

  assign a = bus.R0_alu;
  assign b = bus.RX_alu;

  always_comb begin
    res     = '0;
    acarreo = 1'b0;
    case (bus.Operacion_alu)
      OP_SUMA:     {acarreo, res} = {1'b0, a} + {1'b0, b};
      // acarreo doubles as borrow for subtraction
      OP_RESTA:    {acarreo, res} = {1'b0, a} - {1'b0, b};
      OP_DESP_IZQ: {acarreo, res} = {a, 1'b0};
      OP_DESP_DER: {res, acarreo} = {1'b0, a};
      // NOT works on the selected register, not on R0
      OP_NOT:      res = ~b;
      OP_AND:      res = a & b;
      OP_OR:       res = a | b;
      OP_XOR:      res = a ^ b;
      default:     res = '0;
    endcase
  end

  assign bus.Resultado_alu = res;
  assign bus.Banderas_alu  = {acarreo, res[7], (res == 8'd0)};

endmodule

// File: rtl/banco_registros.sv
// Purpose : N_REG x 8-bit register file, one write port, two combinational reads.
// Latency : write visible on read ports the cycle after the write edge.
// Backpr. : none; a write is taken on every edge where we=1.
// Ports   : clk, rst_n (async, active-low); we/waddr/wdata write port;
//           raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module banco_registros #(
  parameter int N_REG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs_q [N_REG];
  logic [7:0] regs_d [N_REG];

  always_comb begin
    for (int i = 0; i < N_REG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/secuenciador_alu.sv
// Purpose : 4-state instruction sequencer feeding an external ALU, writeback to R0.
// Latency : listo pulses 3 cycles after the accepting edge (LEE, EJECUTA, FIN).
// Backpr. : ocupado high outside IDLE; inicio/carga_en dropped while busy.
// Ports   : clk, rst_n (async, active-low); bus.slave carries the host
//           request/load/status signals and the ALU operand/result signals.
module secuenciador_alu
  import secuenciador_alu_pkg::*;
#(
  parameter int N_REG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  secuenciador_alu_if.slave    bus
);

  estado_t    estado_q, estado_d;
  logic [3:0] instr_op_q, instr_op_d;
  logic [1:0] instr_rx_q, instr_rx_d;
  logic [7:0] r0_alu_q, r0_alu_d;
  logic [7:0] rx_alu_q, rx_alu_d;
  logic [3:0] op_alu_q, op_alu_d;
  logic [2:0] banderas_q, banderas_d;
  logic [7:0] cuenta_q, cuenta_d;

  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_r0;
  logic [7:0] rf_rx;

  // Port A is hard-wired to R0; port B follows the latched RX index.
  banco_registros #(
    .N_REG (N_REG)
  ) u_banco (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (2'd0),
    .rdata_a (rf_r0),
    .raddr_b (instr_rx_q),
    .rdata_b (rf_rx)
  );

  // Next state, latches and counters.
  always_comb begin
    estado_d   = estado_q;
    instr_op_d = instr_op_q;
    instr_rx_d = instr_rx_q;
    r0_alu_d   = r0_alu_q;
    rx_alu_d   = rx_alu_q;
    op_alu_d   = op_alu_q;
    banderas_d = banderas_q;
    cuenta_d   = cuenta_q;
    case (estado_q)
      IDLE: begin
        if (bus.inicio) begin
          instr_op_d = bus.instruccion[7:4];
          instr_rx_d = bus.instruccion[1:0];
          estado_d   = LEE;
        end
      end
      LEE: begin
        // Operands are captured at the end of LEE so a load made on the
        // accepting edge is already visible in the register file.
        r0_alu_d = rf_r0;
        rx_alu_d = rf_rx;
        op_alu_d = instr_op_q;
        estado_d = EJECUTA;
      end
      EJECUTA: begin
        if (op_escribe(op_alu_q)) begin
          banderas_d = bus.Banderas_alu;
        end
        estado_d = FIN;
      end
      FIN: begin
        cuenta_d = cuenta_q + 8'd1;
        // Operands stay as they were; only the opcode returns to NOP.
        op_alu_d = OP_NOP;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // Register-file write port: host load in IDLE, ALU writeback to R0 in EJECUTA.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 2'd0;
    rf_wdata = 8'd0;
    if (estado_q == IDLE && bus.carga_en) begin
      rf_we    = 1'b1;
      rf_waddr = bus.carga_dir;
      rf_wdata = bus.carga_dato;
    end else if (estado_q == EJECUTA && op_escribe(op_alu_q)) begin
      rf_we    = 1'b1;
      rf_waddr = 2'd0;
      rf_wdata = bus.Resultado_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      instr_op_q <= OP_NOP;
      instr_rx_q <= 2'd0;
      r0_alu_q   <= 8'd0;
      rx_alu_q   <= 8'd0;
      op_alu_q   <= OP_NOP;
      banderas_q <= 3'd0;
      cuenta_q   <= 8'd0;
    end else begin
      estado_q   <= estado_d;
      instr_op_q <= instr_op_d;
      instr_rx_q <= instr_rx_d;
      r0_alu_q   <= r0_alu_d;
      rx_alu_q   <= rx_alu_d;
      op_alu_q   <= op_alu_d;
      banderas_q <= banderas_d;
      cuenta_q   <= cuenta_d;
    end
  end

  assign bus.ocupado       = (estado_q != IDLE);
  assign bus.listo         = (estado_q == FIN);
  assign bus.error         = (estado_q == FIN) && op_invalido(op_alu_q);
  assign bus.r0_actual     = rf_r0;
  assign bus.banderas      = banderas_q;
  assign bus.cuenta_ops    = cuenta_q;
  assign bus.R0_alu        = r0_alu_q;
  assign bus.RX_alu        = rx_alu_q;
  assign bus.Operacion_alu = op_alu_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
module tb_secuenciador_alu;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n;
  int   pulsos;

  secuenciador_alu_if bus ();

  secuenciador_alu #(.N_REG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_8b u_alu (
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic cargar(input logic [1:0] dir, input logic [7:0] dato);
    @(negedge clk);
    bus.carga_en   = 1'b1;
    bus.carga_dir  = dir;
    bus.carga_dato = dato;
    @(negedge clk);
    bus.carga_en   = 1'b0;
  endtask

  // Returns at the negedge inside LEE (first cycle after the accepting edge).
  task automatic lanzar(input logic [7:0] ins);
    @(negedge clk);
    bus.inicio      = 1'b1;
    bus.instruccion = ins;
    @(negedge clk);
    bus.inicio      = 1'b0;
  endtask

  // From LEE, counts cycles until listo (LEE = 1); bounded.
  task automatic esperar_listo(output int cyc);
    cyc = 1;
    while (!bus.listo && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got=%b exp=0", bus.ocupado); end
    checks++; if (bus.listo !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL reset_listo_error got=%b%b exp=00", bus.listo, bus.error); end
    checks++; if (bus.r0_actual !== 8'h00 || bus.banderas !== 3'b000 || bus.cuenta_ops !== 8'h00) begin
      errors++; $display("FAIL reset_estado got r0=%h fl=%b cnt=%h exp 00/000/00", bus.r0_actual, bus.banderas, bus.cuenta_ops); end
    checks++; if (bus.R0_alu !== 8'h00 || bus.RX_alu !== 8'h00 || bus.Operacion_alu !== 4'h0) begin
      errors++; $display("FAIL reset_alu_ops got %h %h %h exp 00 00 0", bus.R0_alu, bus.RX_alu, bus.Operacion_alu); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_suma;
    cargar(2'd0, 8'h05);
    cargar(2'd1, 8'h03);
    lanzar(8'h81);
    checks++; if (bus.ocupado !== 1'b1 || bus.listo !== 1'b0) begin errors++; $display("FAIL suma_lee got ocupado=%b listo=%b exp 1 0", bus.ocupado, bus.listo); end
    @(negedge clk); // EJECUTA
    checks++; if (bus.R0_alu !== 8'h05 || bus.RX_alu !== 8'h03 || bus.Operacion_alu !== 4'h8) begin
      errors++; $display("FAIL suma_operandos got %h %h %h exp 05 03 8", bus.R0_alu, bus.RX_alu, bus.Operacion_alu); end
    checks++; if (bus.listo !== 1'b0) begin errors++; $display("FAIL suma_listo_temprano got=1 exp=0"); end
    @(negedge clk); // FIN
    checks++; if (bus.listo !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL suma_fin got listo=%b error=%b exp 1 0", bus.listo, bus.error); end
    @(negedge clk); // IDLE
    checks++; if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin errors++; $display("FAIL suma_idle got listo=%b ocupado=%b exp 0 0", bus.listo, bus.ocupado); end
    checks++; if (bus.r0_actual !== 8'h08 || bus.cuenta_ops !== 8'd1 || bus.banderas !== 3'b000) begin
      errors++; $display("FAIL suma_resultado got r0=%h cnt=%0d fl=%b exp 08 1 000", bus.r0_actual, bus.cuenta_ops, bus.banderas); end
    checks++; if (bus.Operacion_alu !== 4'h0 || bus.R0_alu !== 8'h05 || bus.RX_alu !== 8'h03) begin
      errors++; $display("FAIL suma_idle_hold got %h %h %h exp 0 05 03", bus.Operacion_alu, bus.R0_alu, bus.RX_alu); end
  endtask

  task automatic test_resta_not;
    cargar(2'd0, 8'h05);
    lanzar(8'h91);
    esperar_listo(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL resta_latencia got=%0d exp=3", n); end
    @(negedge clk);
    checks++; if (bus.r0_actual !== 8'h02 || bus.banderas !== 3'b000) begin
      errors++; $display("FAIL resta got r0=%h fl=%b exp 02 000", bus.r0_actual, bus.banderas); end
    lanzar(8'hC1);
    @(negedge clk); // EJECUTA
    checks++; if (bus.Banderas_alu !== 3'b010 || bus.Resultado_alu !== 8'hFC) begin
      errors++; $display("FAIL not_alu got res=%h fl=%b exp FC 010", bus.Resultado_alu, bus.Banderas_alu); end
    @(negedge clk); @(negedge clk);
    checks++; if (bus.r0_actual !== 8'hFC || bus.banderas !== 3'b010 || bus.cuenta_ops !== 8'd3) begin
      errors++; $display("FAIL not got r0=%h fl=%b cnt=%0d exp FC 010 3", bus.r0_actual, bus.banderas, bus.cuenta_ops); end
  endtask

  task automatic test_rx_r0;
    lanzar(8'h80);
    @(negedge clk); // EJECUTA
    checks++; if (bus.R0_alu !== 8'hFC || bus.RX_alu !== 8'hFC) begin
      errors++; $display("FAIL rx_r0_operandos got %h %h exp FC FC", bus.R0_alu, bus.RX_alu); end
    @(negedge clk); @(negedge clk);
    checks++; if (bus.r0_actual !== 8'hF8 || bus.banderas !== 3'b110) begin
      errors++; $display("FAIL rx_r0 got r0=%h fl=%b exp F8 110", bus.r0_actual, bus.banderas); end
  endtask

  task automatic test_carga_simultanea;
    @(negedge clk);
    bus.inicio = 1'b1; bus.instruccion = 8'h82;
    bus.carga_en = 1'b1; bus.carga_dir = 2'd2; bus.carga_dato = 8'h10;
    @(negedge clk); // LEE
    bus.inicio = 1'b0; bus.carga_en = 1'b0;
    @(negedge clk); // EJECUTA
    checks++; if (bus.R0_alu !== 8'hF8 || bus.RX_alu !== 8'h10) begin
      errors++; $display("FAIL simultanea_operandos got %h %h exp F8 10", bus.R0_alu, bus.RX_alu); end
    @(negedge clk); @(negedge clk);
    checks++; if (bus.r0_actual !== 8'h08 || bus.banderas !== 3'b100) begin
      errors++; $display("FAIL simultanea got r0=%h fl=%b exp 08 100", bus.r0_actual, bus.banderas); end
  endtask

  task automatic test_ignora_ocupado;
    lanzar(8'h81);
    bus.inicio = 1'b1; bus.instruccion = 8'h81;
    bus.carga_en = 1'b1; bus.carga_dir = 2'd1; bus.carga_dato = 8'h77;
    pulsos = 0;
    @(negedge clk);
    bus.inicio = 1'b0; bus.carga_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.listo) pulsos++;
      @(negedge clk);
    end
    checks++; if (pulsos !== 1) begin errors++; $display("FAIL ocupado_un_listo got=%0d exp=1", pulsos); end
    checks++; if (bus.r0_actual !== 8'h0B) begin errors++; $display("FAIL ocupado_r0 got=%h exp=0B", bus.r0_actual); end
    lanzar(8'hC1);
    @(negedge clk); // EJECUTA
    checks++; if (bus.RX_alu !== 8'h03) begin errors++; $display("FAIL ocupado_r1 got=%h exp=03", bus.RX_alu); end
    @(negedge clk); @(negedge clk);
    checks++; if (bus.r0_actual !== 8'hFC || bus.cuenta_ops !== 8'd7) begin
      errors++; $display("FAIL ocupado_cuenta got r0=%h cnt=%0d exp FC 7", bus.r0_actual, bus.cuenta_ops); end
  endtask

  task automatic test_invalido_nop;
    lanzar(8'h31);
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL invalido_error_lee got=1 exp=0"); end
    esperar_listo(n);
    checks++; if (n !== 3 || bus.error !== 1'b1) begin errors++; $display("FAIL invalido_fin got cyc=%0d error=%b exp 3 1", n, bus.error); end
    @(negedge clk);
    checks++; if (bus.error !== 1'b0 || bus.r0_actual !== 8'hFC || bus.banderas !== 3'b010 || bus.cuenta_ops !== 8'd8) begin
      errors++; $display("FAIL invalido got err=%b r0=%h fl=%b cnt=%0d exp 0 FC 010 8", bus.error, bus.r0_actual, bus.banderas, bus.cuenta_ops); end
    lanzar(8'h00);
    esperar_listo(n);
    checks++; if (n !== 3 || bus.error !== 1'b0) begin errors++; $display("FAIL nop_fin got cyc=%0d error=%b exp 3 0", n, bus.error); end
    @(negedge clk);
    checks++; if (bus.r0_actual !== 8'hFC || bus.banderas !== 3'b010 || bus.cuenta_ops !== 8'd9) begin
      errors++; $display("FAIL nop got r0=%h fl=%b cnt=%0d exp FC 010 9", bus.r0_actual, bus.banderas, bus.cuenta_ops); end
  endtask

  task automatic test_reset_medio;
    lanzar(8'h81);
    @(negedge clk); // EJECUTA
    checks++; if (bus.Operacion_alu !== 4'h8) begin errors++; $display("FAIL medio_ejecuta got op=%h exp 8", bus.Operacion_alu); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ocupado !== 1'b0 || bus.listo !== 1'b0 || bus.error !== 1'b0) begin
      errors++; $display("FAIL medio_ctrl got %b%b%b exp 000", bus.ocupado, bus.listo, bus.error); end
    checks++; if (bus.r0_actual !== 8'h00 || bus.banderas !== 3'b000 || bus.cuenta_ops !== 8'h00 ||
                  bus.R0_alu !== 8'h00 || bus.RX_alu !== 8'h00 || bus.Operacion_alu !== 4'h0) begin
      errors++; $display("FAIL medio_datos got r0=%h fl=%b cnt=%h a=%h b=%h op=%h exp all 0",
                         bus.r0_actual, bus.banderas, bus.cuenta_ops, bus.R0_alu, bus.RX_alu, bus.Operacion_alu); end
    @(negedge clk);
    rst_n = 1'b1;
    pulsos = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.listo || bus.ocupado) pulsos++;
    end
    checks++; if (pulsos !== 0 || bus.r0_actual !== 8'h00) begin
      errors++; $display("FAIL medio_sin_listo got activos=%0d r0=%h exp 0 00", pulsos, bus.r0_actual); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 255; i++) begin
      lanzar(8'h00);
      esperar_listo(n);
      @(negedge clk);
    end
    checks++; if (bus.cuenta_ops !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", bus.cuenta_ops); end
    lanzar(8'h00);
    esperar_listo(n);
    @(negedge clk);
    checks++; if (bus.cuenta_ops !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", bus.cuenta_ops); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.inicio = 1'b0;
    bus.instruccion = 8'h00;
    bus.carga_en = 1'b0;
    bus.carga_dir = 2'd0;
    bus.carga_dato = 8'h00;
    test_reset();
    test_suma();
    test_resta_not();
    test_rx_r0();
    test_carga_simultanea();
    test_ignora_ocupado();
    test_invalido_nop();
    test_reset_medio();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
